traffic_phase_scheduler: RTL and testbench
==========================================

TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 4: minimum green cycles per approach.
REQ-002 The block SHALL have parameter MAX_GREEN, default 10: maximum green cycles when cross demand exists.
REQ-003 The block SHALL have parameter YELLOW_T, default 2: yellow duration in cycles.
REQ-004 The block SHALL have parameter ALLRED_T, default 1: all-red clearance duration in cycles.
REQ-005 The block SHALL have parameter WALK_T, default 3: pedestrian walk duration in cycles.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous reset, active-high.
REQ-008 The block SHALL have port traffic_A, input, 1 bit: vehicle present on approach A (level).
REQ-009 The block SHALL have port traffic_B, input, 1 bit: vehicle present on approach B (level).
REQ-010 The block SHALL have port ped_req, input, 1 bit: pedestrian button (pulse or level).
REQ-011 The block SHALL have port LA, output, 2 bits: light A; 00 = GREEN, 01 = YELLOW, 10 = RED.
REQ-012 The block SHALL have port LB, output, 2 bits: light B, with the same encoding as LA.
REQ-013 The block SHALL have port walk, output, 1 bit: pedestrian walk signal.
REQ-014 The block SHALL have port phase, output, 3 bits: current state code, as listed in REQ-017.
REQ-015 The block SHALL have port ped_pend, output, 1 bit: latched pedestrian request.

Function
REQ-016 The block SHALL use only clk and reset (synchronous, active-high); all state SHALL update on the rising edge of clk.
REQ-017 The block SHALL implement these states and codes:
- A_GREEN = 0
- A_YEL = 1
- RED_AB = 2
- B_GREEN = 3
- B_YEL = 4
- RED_BA = 5
- WALK_AB = 6
- WALK_BA = 7
REQ-018 The outputs SHALL be Moore-decoded from the state register:
- A_GREEN: LA = GREEN
- A_YEL: LA = YELLOW
- B_GREEN: LB = GREEN
- B_YEL: LB = YELLOW
- All other cases: each light = RED
- walk = 1 only in WALK_AB and WALK_BA
REQ-019 An 8-bit dwell counter cnt SHALL clear to 0 on every state change and increment by 1 per cycle otherwise, saturating at 255.
REQ-020 A_GREEN SHALL exit to A_YEL when all three hold: cnt >= MIN_GREEN-1; (traffic_B or ped_pend); (!traffic_A or cnt >= MAX_GREEN-1).
REQ-021 A_GREEN SHALL otherwise hold, with no upper bound when no cross demand exists.
REQ-022 B_GREEN SHALL exit to B_YEL symmetrically, with traffic_A and traffic_B swapped.
REQ-023 Fixed-duration states SHALL last exactly their parameter in cycles, exiting when cnt == param-1:
- A_YEL -> RED_AB
- B_YEL -> RED_BA
- RED_AB -> WALK_AB if ped_pend, else B_GREEN
- RED_BA -> WALK_BA if ped_pend, else A_GREEN
- WALK_AB -> B_GREEN
- WALK_BA -> A_GREEN
REQ-024 ped_pend SHALL set on any cycle with ped_req = 1, except the cycle of entry into a WALK state and cycles spent in a WALK state.
REQ-025 ped_pend SHALL clear on entry into WALK_AB or WALK_BA.
REQ-026 A request coincident with WALK entry, or arriving during WALK, SHALL be absorbed and SHALL NOT be latched.
REQ-027 traffic_A and traffic_B SHALL be sampled with no latching; only the current-cycle level counts.
REQ-028 Both lights SHALL never be non-RED in the same cycle.
REQ-029 A light SHALL never go directly from GREEN to RED, or from RED to YELLOW.
REQ-030 Parameters SHALL satisfy all of the following; otherwise elaboration SHALL stop with an error:
- 1 <= MIN_GREEN <= MAX_GREEN <= 255
- YELLOW_T, ALLRED_T and WALK_T each in 1..255

Reset
REQ-031 While reset = 1 at a clock edge, the block SHALL load state = RED_BA, cnt = 0, ped_pend = 0.
REQ-032 Consequently, the outputs SHALL be LA = RED, LB = RED, walk = 0, phase = 5.
REQ-033 Reset asserted in any state, mid-dwell, SHALL take effect at the next edge, overriding all transitions and ped_req.
REQ-034 After reset is released, RED_BA SHALL last ALLRED_T cycles and then go to A_GREEN; ped_pend is 0, so WALK_BA is not entered.

Verification
REQ-035 Scenario 1, defaults:
- Stimulus: reset for 2 cycles, then traffic_A = traffic_B = ped_req = 0.
- Response: LA = LB = RED for 1 cycle, then LA = GREEN, held for 50 cycles with no change.
REQ-036 Scenario 2:
- Stimulus: after reset, traffic_B = 1, traffic_A = 0.
- Response: A_GREEN for 4 cycles, A_YEL 2, RED_AB 1, then B_GREEN held while traffic_B = 1 and traffic_A = 0.
REQ-037 Scenario 3:
- Stimulus: traffic_A = traffic_B = 1 continuously.
- Response: repeating 26-cycle cycle of A_GREEN 10, A_YEL 2, RED_AB 1, B_GREEN 10, B_YEL 2, RED_BA 1.
REQ-038 Scenario 4:
- Stimulus: one-cycle ped_req in A_GREEN at cnt = 1, no traffic.
- Response: ped_pend = 1 next cycle; A_GREEN ends after 4 cycles; A_YEL 2, RED_AB 1, WALK_AB 3 with walk = 1 and LA = LB = RED; ped_pend = 0 from WALK entry; then B_GREEN.
REQ-039 Scenario 5:
- Stimulus: ped_req = 1 held through WALK_AB.
- Response: ped_pend stays 0 throughout WALK_AB and goes to 1 on the first cycle of B_GREEN.
REQ-040 Scenario 6:
- Stimulus: reset asserted for 1 cycle during B_YEL with ped_pend = 1.
- Response: next cycle phase = 5, LA = LB = RED, walk = 0, ped_pend = 0; 1 cycle later LA = GREEN.
REQ-041 Every scenario SHALL check REQ-028 and REQ-029 on every cycle.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Two-approach traffic light scheduler with a pedestrian walk phase.
// Approach A and B alternate green; each change of right-of-way passes
// through yellow and an all-red clearance, and a latched pedestrian
// request inserts a walk phase after the all-red interval.
module traffic_phase_scheduler #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       traffic_A,
    input  logic       traffic_B,
    input  logic       ped_req,
    output logic [1:0] LA,
    output logic [1:0] LB,
    output logic       walk,
    output logic [2:0] phase,
    output logic       ped_pend
);

    localparam logic [2:0] A_GREEN = 3'd0;
    localparam logic [2:0] A_YEL   = 3'd1;
    localparam logic [2:0] RED_AB  = 3'd2;
    localparam logic [2:0] B_GREEN = 3'd3;
    localparam logic [2:0] B_YEL   = 3'd4;
    localparam logic [2:0] RED_BA  = 3'd5;
    localparam logic [2:0] WALK_AB = 3'd6;
    localparam logic [2:0] WALK_BA = 3'd7;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    // Dwell thresholds expressed as the last counter value of each interval.
    localparam logic [7:0] MIN_LAST    = 8'(MIN_GREEN - 1);
    localparam logic [7:0] MAX_LAST    = 8'(MAX_GREEN - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_T - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_T - 1);
    localparam logic [7:0] WALK_LAST   = 8'(WALK_T - 1);

    // Out-of-range timing parameters would make the dwell counter unable to
    // reach its exit value, so refuse to elaborate with them.
    if (MIN_GREEN < 1 || MIN_GREEN > MAX_GREEN || MAX_GREEN > 255 ||
        YELLOW_T < 1 || YELLOW_T > 255 ||
        ALLRED_T < 1 || ALLRED_T > 255 ||
        WALK_T < 1 || WALK_T > 255) begin : g_bad_params
        $error("traffic_phase_scheduler: illegal timing parameters");
    end

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ped_pend_q, ped_pend_d;
    logic       a_green_done;
    logic       b_green_done;

    // Green exit: minimum served, cross demand present, and either own
    // approach empty or the maximum green reached.
    always_comb begin
        a_green_done = (cnt_q >= MIN_LAST) && (traffic_B || ped_pend_q) &&
                       (!traffic_A || (cnt_q >= MAX_LAST));
        b_green_done = (cnt_q >= MIN_LAST) && (traffic_A || ped_pend_q) &&
                       (!traffic_B || (cnt_q >= MAX_LAST));
    end

    // Next-state selection for the phase sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            A_GREEN: if (a_green_done) state_d = A_YEL;
            A_YEL:   if (cnt_q == YELLOW_LAST) state_d = RED_AB;
            RED_AB:  if (cnt_q == ALLRED_LAST) state_d = ped_pend_q ? WALK_AB : B_GREEN;
            B_GREEN: if (b_green_done) state_d = B_YEL;
            B_YEL:   if (cnt_q == YELLOW_LAST) state_d = RED_BA;
            RED_BA:  if (cnt_q == ALLRED_LAST) state_d = ped_pend_q ? WALK_BA : A_GREEN;
            WALK_AB: if (cnt_q == WALK_LAST) state_d = B_GREEN;
            WALK_BA: if (cnt_q == WALK_LAST) state_d = A_GREEN;
            default: state_d = RED_BA;
        endcase
    end

    // Dwell counter restarts on every phase change and saturates at 255 so a
    // long idle green never wraps back into the minimum-green window.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == 8'hFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Pedestrian latch: being in or entering a walk phase serves the request
    // and swallows any press made meanwhile; otherwise presses accumulate.
    always_comb begin
        if (state_d == WALK_AB || state_d == WALK_BA) begin
            ped_pend_d = 1'b0;
        end else begin
            ped_pend_d = ped_pend_q || ped_req;
        end
    end

    // State registers with synchronous reset into the B-to-A all-red phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RED_BA;
            cnt_q      <= 8'd0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    // Moore output decode straight from the phase register.
    always_comb begin
        LA   = LIGHT_RED;
        LB   = LIGHT_RED;
        walk = 1'b0;
        case (state_q)
            A_GREEN: LA = LIGHT_GREEN;
            A_YEL:   LA = LIGHT_YELLOW;
            B_GREEN: LB = LIGHT_GREEN;
            B_YEL:   LB = LIGHT_YELLOW;
            WALK_AB: walk = 1'b1;
            WALK_BA: walk = 1'b1;
            default: ;
        endcase
        phase    = state_q;
        ped_pend = ped_pend_q;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Self-checking bench for traffic_phase_scheduler: directed scenarios plus a
// randomized run, all compared against a behavioural phase model.
module tb_traffic_phase_scheduler;

    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 10;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int WALK_T    = 3;

    localparam logic [1:0] G = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] R = 2'b10;

    logic       clk;
    logic       reset;
    logic       traffic_A;
    logic       traffic_B;
    logic       ped_req;
    logic [1:0] LA;
    logic [1:0] LB;
    logic       walk;
    logic [2:0] phase;
    logic       ped_pend;

    int checks;
    int failures;
    int cyc;

    // Behavioural model: phase number, cycles already spent in it, pending flag.
    int m_phase;
    int m_dwell;
    bit m_pend;

    logic [1:0] prev_la;
    logic [1:0] prev_lb;
    bit         skip_trans;

    traffic_phase_scheduler #(
        .MIN_GREEN(MIN_GREEN),
        .MAX_GREEN(MAX_GREEN),
        .YELLOW_T (YELLOW_T),
        .ALLRED_T (ALLRED_T),
        .WALK_T   (WALK_T)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .traffic_A(traffic_A),
        .traffic_B(traffic_B),
        .ped_req  (ped_req),
        .LA       (LA),
        .LB       (LB),
        .walk     (walk),
        .phase    (phase),
        .ped_pend (ped_pend)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Advance the model by one clock with the inputs that were sampled.
    task automatic model_step(input bit ta, input bit tb, input bit pr, input bit rst);
        int nxt;
        int elapsed;
        if (rst) begin
            m_phase = 5;
            m_dwell = 0;
            m_pend  = 0;
            return;
        end
        elapsed = m_dwell + 1;
        nxt = m_phase;
        case (m_phase)
            0: if (elapsed >= MIN_GREEN && (tb || m_pend) && (!ta || elapsed >= MAX_GREEN)) nxt = 1;
            3: if (elapsed >= MIN_GREEN && (ta || m_pend) && (!tb || elapsed >= MAX_GREEN)) nxt = 4;
            1: if (elapsed == YELLOW_T) nxt = 2;
            4: if (elapsed == YELLOW_T) nxt = 5;
            2: if (elapsed == ALLRED_T) nxt = m_pend ? 6 : 3;
            5: if (elapsed == ALLRED_T) nxt = m_pend ? 7 : 0;
            6: if (elapsed == WALK_T) nxt = 3;
            7: if (elapsed == WALK_T) nxt = 0;
            default: nxt = 5;
        endcase
        if (nxt == 6 || nxt == 7) m_pend = 0;
        else m_pend = m_pend | pr;
        if (nxt != m_phase) m_dwell = 0;
        else m_dwell = (elapsed > 255) ? 255 : elapsed;
        m_phase = nxt;
    endtask

    function automatic logic [8:0] exp_vec();
        logic [1:0] la;
        logic [1:0] lb;
        la = (m_phase == 0) ? G : (m_phase == 1) ? Y : R;
        lb = (m_phase == 3) ? G : (m_phase == 4) ? Y : R;
        return {la, lb, (m_phase >= 6) ? 1'b1 : 1'b0, 3'(m_phase), m_pend};
    endfunction

    function automatic logic [8:0] obs_vec();
        return {LA, LB, walk, phase, ped_pend};
    endfunction

    // True when the current lights are conflict-free and the step from the
    // previous cycle's lights is a permitted one (reset steps excepted).
    function automatic bit legal();
        bit ok;
        ok = 1'b1;
        if (LA !== R && LB !== R) ok = 1'b0;
        if (!skip_trans) begin
            if (prev_la === G && LA === R) ok = 1'b0;
            if (prev_la === R && LA === Y) ok = 1'b0;
            if (prev_lb === G && LB === R) ok = 1'b0;
            if (prev_lb === R && LB === Y) ok = 1'b0;
        end
        return ok;
    endfunction

    // Drive one cycle of inputs, clock it, and advance the model.
    task automatic run_cycle(input bit ta, input bit tb, input bit pr, input bit rst);
        prev_la   = LA;
        prev_lb   = LB;
        traffic_A = ta;
        traffic_B = tb;
        ped_req   = pr;
        reset     = rst;
        @(posedge clk);
        model_step(ta, tb, pr, rst);
        skip_trans = rst;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        run_cycle(0, 0, 0, 1);
        run_cycle(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_model cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
        end
        checks++;
        if ({LA, LB, walk, phase, ped_pend} !== {R, R, 1'b0, 3'd5, 1'b0}) begin
            failures++;
            $display("FAIL reset_state cycle=%0d got=%b_%b_%b_%0d_%b expected=10_10_0_5_0",
                     cyc, LA, LB, walk, phase, ped_pend);
        end
    endtask

    task automatic test_idle();
        int greens;
        greens = 0;
        do_reset();
        for (int i = 0; i < 50; i++) begin
            run_cycle(0, 0, 0, 0);
            if (LA === G) greens++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL idle_model cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (!legal()) begin
                failures++;
                $display("FAIL idle_lights cycle=%0d got=%b_%b expected=legal", cyc, LA, LB);
            end
        end
        checks++;
        if (greens != 50) begin
            failures++;
            $display("FAIL idle_green_hold got=%0d expected=50", greens);
        end
    endtask

    task automatic test_b_demand();
        int a_green;
        int a_yel;
        a_green = 0;
        a_yel   = 0;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            run_cycle(0, 1, 0, 0);
            if (phase === 3'd0) a_green++;
            if (phase === 3'd1) a_yel++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL bdem_model cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (!legal()) begin
                failures++;
                $display("FAIL bdem_lights cycle=%0d got=%b_%b expected=legal", cyc, LA, LB);
            end
        end
        checks++;
        if (a_green != 4 || a_yel != 2 || phase !== 3'd3) begin
            failures++;
            $display("FAIL bdem_durations got=%0d/%0d/ph%0d expected=4/2/ph3", a_green, a_yel, phase);
        end
    endtask

    task automatic test_both_demand();
        int a_green;
        int b_green;
        a_green = 0;
        b_green = 0;
        do_reset();
        for (int i = 0; i < 52; i++) begin
            run_cycle(1, 1, 0, 0);
            if (LA === G) a_green++;
            if (LB === G) b_green++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL both_model cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (!legal()) begin
                failures++;
                $display("FAIL both_lights cycle=%0d got=%b_%b expected=legal", cyc, LA, LB);
            end
        end
        checks++;
        if (a_green != 20 || b_green != 20 || phase !== 3'd5) begin
            failures++;
            $display("FAIL both_period got=%0d/%0d/ph%0d expected=20/20/ph5", a_green, b_green, phase);
        end
    endtask

    task automatic test_ped_pulse();
        int a_green;
        int walks;
        a_green = 0;
        walks   = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            run_cycle(0, 0, (i == 2), 0);
            if (phase === 3'd0) a_green++;
            if (walk === 1'b1 && LA === R && LB === R && ped_pend === 1'b0) walks++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL ped_model cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (!legal()) begin
                failures++;
                $display("FAIL ped_lights cycle=%0d got=%b_%b expected=legal", cyc, LA, LB);
            end
        end
        checks++;
        if (a_green != 4 || walks != 3 || phase !== 3'd3) begin
            failures++;
            $display("FAIL ped_sequence got=%0d/%0d/ph%0d expected=4/3/ph3", a_green, walks, phase);
        end
    endtask

    task automatic test_ped_hold();
        do_reset();
        run_cycle(0, 0, 1, 0);
        for (int i = 0; i < 20 && phase !== 3'd6; i++) begin
            run_cycle(0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_model cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (phase !== 3'd6) begin
            failures++;
            $display("FAIL hold_reach_walk got=ph%0d expected=ph6", phase);
        end
        for (int i = 0; i < 20 && phase === 3'd6; i++) begin
            checks++;
            if (ped_pend !== 1'b0) begin
                failures++;
                $display("FAIL hold_pend_in_walk cycle=%0d got=%b expected=0", cyc, ped_pend);
            end
            run_cycle(0, 0, 1, 0);
            checks++;
            if (!legal()) begin
                failures++;
                $display("FAIL hold_lights cycle=%0d got=%b_%b expected=legal", cyc, LA, LB);
            end
        end
        checks++;
        if (phase !== 3'd3 || ped_pend !== 1'b1) begin
            failures++;
            $display("FAIL hold_after_walk got=ph%0d/pend%b expected=ph3/pend1", phase, ped_pend);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 20 && phase !== 3'd3; i++) run_cycle(0, 1, 0, 0);
        run_cycle(0, 1, 1, 0);
        for (int i = 0; i < 30 && phase !== 3'd4; i++) begin
            run_cycle(0, 0, 0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rmid_model cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (phase !== 3'd4 || ped_pend !== 1'b1) begin
            failures++;
            $display("FAIL rmid_setup got=ph%0d/pend%b expected=ph4/pend1", phase, ped_pend);
        end
        run_cycle(1, 1, 1, 1);
        checks++;
        if ({LA, LB, walk, phase, ped_pend} !== {R, R, 1'b0, 3'd5, 1'b0}) begin
            failures++;
            $display("FAIL rmid_reset got=%b_%b_%b_%0d_%b expected=10_10_0_5_0",
                     LA, LB, walk, phase, ped_pend);
        end
        run_cycle(0, 0, 0, 0);
        checks++;
        if (LA !== G || phase !== 3'd0) begin
            failures++;
            $display("FAIL rmid_release got=%b/ph%0d expected=00/ph0", LA, phase);
        end
    endtask

    task automatic test_random();
        bit ta;
        bit tb;
        do_reset();
        ta = 0;
        tb = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) ta = !ta;
            if ($urandom_range(0, 7) == 0) tb = !tb;
            run_cycle(ta, tb, ($urandom_range(0, 15) == 0), ($urandom_range(0, 199) == 0));
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rand_model cycle=%0d got=%h expected=%h", cyc, obs_vec(), exp_vec());
            end
            checks++;
            if (!legal()) begin
                failures++;
                $display("FAIL rand_lights cycle=%0d got=%b_%b expected=legal", cyc, LA, LB);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        clk        = 0;
        reset      = 1;
        traffic_A  = 0;
        traffic_B  = 0;
        ped_req    = 0;
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        m_phase    = 5;
        m_dwell    = 0;
        m_pend     = 0;
        prev_la    = R;
        prev_lb    = R;
        skip_trans = 1;
        test_reset();
        test_idle();
        test_b_demand();
        test_both_demand();
        test_ped_pulse();
        test_ped_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
